// File: rtl/chime_pkg.sv
// Shared types and helpers for the hourly chime: FSM states, BCD hour decode
// and the quiet-window test.
package chime_pkg;

  localparam int STRIKE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } chime_state_e;

  typedef struct packed {
    logic                valid;
    logic [STRIKE_W-1:0] bin;
  } hour_bin_t;

  // Valid only for two decimal digits forming 00..23; bin is meaningless otherwise.
  function automatic hour_bin_t bcd2bin(input logic [7:0] bcd);
    hour_bin_t  r;
    logic [7:0] v;
    v       = 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]);
    r.valid = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9) && (v <= 8'd23);
    r.bin   = v[STRIKE_W-1:0];
    return r;
  endfunction

  // Window is [q_start, q_end), wrapping past midnight when q_start > q_end.
  function automatic logic in_quiet(input logic [4:0] h,
                                    input logic [4:0] q_start,
                                    input logic [4:0] q_end);
    logic r;
    if (q_start < q_end)      r = (h >= q_start) && (h < q_end);
    else if (q_start > q_end) r = (h >= q_start) || (h < q_end);
    else                      r = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/chime_strike_calc.sv
// Combinational strike count for a BCD hour in 12- or 24-hour mode;
// an invalid hour yields zero strikes.
module chime_strike_calc
  import chime_pkg::*;
(
  input  logic [7:0]          hour,
  input  logic                mode_12h,
  output logic [STRIKE_W-1:0] strikes,
  output logic                valid
);

  hour_bin_t           hb;
  logic [STRIKE_W-1:0] h12;

  always_comb begin
    hb      = bcd2bin(hour);
    valid   = hb.valid;
    h12     = (hb.bin >= 5'd12) ? hb.bin - 5'd12 : hb.bin;
    strikes = '0;
    if (hb.valid) begin
      if (mode_12h) strikes = (h12 == 5'd0) ? 5'd12 : h12;
      else          strikes = (hb.bin == 5'd0) ? 5'd24 : hb.bin;
    end
  end

endmodule

// File: rtl/hour_chime.sv
// Hourly chime: N strikes on the hour, optional single strike on the half hour,
// quiet window and manual trigger. All outputs are registered.
module hour_chime
  import chime_pkg::*;
#(
  parameter int ON_SECS      = 1,
  parameter int OFF_SECS     = 1,
  parameter bit HALF_HOUR_EN = 1'b1,
  parameter int QUIET_START  = 22,
  parameter int QUIET_END    = 7
) (
  input  logic                clk_1hz,
  input  logic                cr,
  input  logic [7:0]          hour,
  input  logic [7:0]          minute,
  input  logic [7:0]          second,
  input  logic                en,
  input  logic                mode_12h,
  input  logic                quiet_en,
  input  logic                man_trig,
  output logic                chime,
  output logic                busy,
  output logic [STRIKE_W-1:0] strikes_left
);

  localparam logic [3:0] ON_LOAD  = 4'(ON_SECS - 1);
  localparam logic [3:0] OFF_LOAD = 4'(OFF_SECS - 1);

  chime_state_e        state, state_n;
  logic [3:0]          phase, phase_n;
  logic                chime_n, busy_n;
  logic [STRIKE_W-1:0] left_n;

  logic [STRIKE_W-1:0] strikes;
  logic                hour_valid;
  hour_bin_t           hb;
  logic                quiet, hour_trig, half_trig, man_go;

  chime_strike_calc u_calc (
    .hour     (hour),
    .mode_12h (mode_12h),
    .strikes  (strikes),
    .valid    (hour_valid)
  );

  always_comb begin
    hb        = bcd2bin(hour);
    quiet     = quiet_en && hb.valid &&
                in_quiet(hb.bin, 5'(QUIET_START), 5'(QUIET_END));
    man_go    = man_trig && (strikes != '0);
    hour_trig = (minute == 8'h00) && (second == 8'h00) && (strikes != '0) && !quiet;
    half_trig = HALF_HOUR_EN && hour_valid && (minute == 8'h30) &&
                (second == 8'h00) && !quiet;
  end

  always_ff @(posedge clk_1hz) begin
    if (cr) begin
      state        <= IDLE;
      phase        <= '0;
      chime        <= 1'b0;
      busy         <= 1'b0;
      strikes_left <= '0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      chime        <= chime_n;
      busy         <= busy_n;
      strikes_left <= left_n;
    end
  end

  // Next-state and next-output logic; chime/busy/strikes_left are computed
  // here so the registered outputs change on the same edge as the state.
  always_comb begin
    state_n = state;
    phase_n = phase;
    chime_n = chime;
    busy_n  = busy;
    left_n  = strikes_left;
    if (!en) begin
      state_n = IDLE;
      phase_n = '0;
      chime_n = 1'b0;
      busy_n  = 1'b0;
      left_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (man_go || hour_trig || half_trig) begin
            state_n = ON;
            phase_n = ON_LOAD;
            chime_n = 1'b1;
            busy_n  = 1'b1;
            left_n  = (man_go || hour_trig) ? strikes : 5'd1;
          end
        end
        ON: begin
          if (phase != '0) begin
            phase_n = phase - 4'd1;
          end else if (strikes_left == 5'd1) begin
            state_n = IDLE;
            chime_n = 1'b0;
            busy_n  = 1'b0;
            left_n  = '0;
          end else begin
            state_n = OFF;
            phase_n = OFF_LOAD;
            chime_n = 1'b0;
            left_n  = strikes_left - 5'd1;
          end
        end
        OFF: begin
          if (phase != '0) begin
            phase_n = phase - 4'd1;
          end else begin
            state_n = ON;
            phase_n = ON_LOAD;
            chime_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          phase_n = '0;
          chime_n = 1'b0;
          busy_n  = 1'b0;
          left_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hour_chime.sv
// Bench for hour_chime: table of trigger vectors plus hand sequences for
// abort, reset, long strikes, half-hour disable and the strike calculator.
module tb_hour_chime;

  logic       clk_1hz = 1'b0;
  logic       cr = 1'b1;
  logic [7:0] hour = 8'h01, minute = 8'h00, second = 8'h01;
  logic       en = 1'b0, mode_12h = 1'b1, quiet_en = 1'b0, man_trig = 1'b0;

  logic       chime, busy, chime_nh, busy_nh, chime_l, busy_l;
  logic [4:0] sl, sl_nh, sl_l;

  logic [7:0] calc_hour = 8'h00;
  logic [4:0] calc_s24, calc_s12;
  logic       calc_v24, calc_v12;

  int errors = 0;
  int checks = 0;

  always #5 clk_1hz = ~clk_1hz;

  hour_chime dut (
    .clk_1hz(clk_1hz), .cr(cr), .hour(hour), .minute(minute), .second(second),
    .en(en), .mode_12h(mode_12h), .quiet_en(quiet_en), .man_trig(man_trig),
    .chime(chime), .busy(busy), .strikes_left(sl)
  );

  hour_chime #(.HALF_HOUR_EN(1'b0)) dut_nh (
    .clk_1hz(clk_1hz), .cr(cr), .hour(hour), .minute(minute), .second(second),
    .en(en), .mode_12h(mode_12h), .quiet_en(quiet_en), .man_trig(man_trig),
    .chime(chime_nh), .busy(busy_nh), .strikes_left(sl_nh)
  );

  hour_chime #(.ON_SECS(2), .OFF_SECS(3)) dut_l (
    .clk_1hz(clk_1hz), .cr(cr), .hour(hour), .minute(minute), .second(second),
    .en(en), .mode_12h(mode_12h), .quiet_en(quiet_en), .man_trig(man_trig),
    .chime(chime_l), .busy(busy_l), .strikes_left(sl_l)
  );

  chime_strike_calc calc24 (.hour(calc_hour), .mode_12h(1'b0), .strikes(calc_s24), .valid(calc_v24));
  chime_strike_calc calc12 (.hour(calc_hour), .mode_12h(1'b1), .strikes(calc_s12), .valid(calc_v12));

  typedef struct {
    logic [7:0] h, m, s;
    logic       m12, qen, man;
    int         n;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy && !busy_nh && !busy_l) break;
      @(negedge clk_1hz);
    end
    chk("idle_wait", {29'd0, busy, busy_nh, busy_l}, 0);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic m12, input logic qen, input logic man);
    @(negedge clk_1hz);
    hour = h; minute = m; second = s;
    mode_12h = m12; quiet_en = qen; man_trig = man;
  endtask

  // Expected default-timing sequence: ON at even cycles, strike count at ON cycles.
  task automatic run_seq(input string name, input int n);
    int len;
    len = (n == 0) ? 0 : 2 * n - 1;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk_1hz);
      if (k == 0) begin second = 8'h01; man_trig = 1'b0; end
      if (k == len) begin
        chk({name, "_end_chime"}, chime, 0);
        chk({name, "_end_busy"}, busy, 0);
        chk({name, "_end_left"}, sl, 0);
      end else begin
        chk($sformatf("%s_chime_%0d", name, k), chime, (k % 2 == 0) ? 1 : 0);
        chk($sformatf("%s_busy_%0d", name, k), busy, 1);
        if (k % 2 == 0) chk($sformatf("%s_left_%0d", name, k), sl, n - k / 2);
      end
    end
  endtask

  initial begin
    logic pat[7];
    int   t, o, b, e24, e12;
    logic ev;

    vecs[0]  = '{8'h15, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3};
    vecs[1]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 24};
    vecs[2]  = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 12};
    vecs[3]  = '{8'h23, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    vecs[4]  = '{8'h06, 8'h30, 8'h00, 1'b1, 1'b1, 1'b0, 0};
    vecs[5]  = '{8'h23, 8'h10, 8'h05, 1'b1, 1'b1, 1'b1, 11};
    vecs[6]  = '{8'h09, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{8'h2A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{8'h13, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 13};
    vecs[9]  = '{8'h12, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 12};
    vecs[10] = '{8'h07, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 7};
    vecs[11] = '{8'h21, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 21};
    vecs[12] = '{8'h22, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 0};
    vecs[13] = '{8'h10, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{8'h19, 8'h59, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    vecs[15] = '{8'h06, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vecs[16] = '{8'h00, 8'h17, 8'h42, 1'b0, 1'b0, 1'b1, 24};
    vecs[17] = '{8'h1A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 0};
    vecs[18] = '{8'h24, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0};
    vecs[19] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0};

    // Reset state
    repeat (2) @(negedge clk_1hz);
    chk("reset_chime", chime, 0);
    chk("reset_busy", busy, 0);
    chk("reset_left", sl, 0);
    cr = 1'b0;
    en = 1'b1;

    // Strike calculator over every hour code
    for (int c = 0; c < 256; c++) begin
      calc_hour = 8'(c);
      t = c / 16; o = c % 16; b = t * 10 + o;
      ev  = (t <= 9) && (o <= 9) && (b <= 23);
      e24 = !ev ? 0 : (b == 0 ? 24 : b);
      e12 = !ev ? 0 : (b % 12 == 0 ? 12 : b % 12);
      #1;
      chk($sformatf("calc24_%02h", c), calc_s24, e24);
      chk($sformatf("calc12_%02h", c), calc_s12, e12);
      chk($sformatf("calcv_%02h", c), calc_v24, ev);
    end

    // Table-driven trigger vectors
    for (int i = 0; i < NV; i++) begin
      wait_idle();
      set_time(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].m12, vecs[i].qen, vecs[i].man);
      run_seq($sformatf("vec%0d", i), vecs[i].n);
    end

    // Drop enable at the fourth strike of 08:00
    wait_idle();
    set_time(8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk_1hz);
      if (k == 0) second = 8'h01;
    end
    chk("en_drop_4th_chime", chime, 1);
    en = 1'b0;
    @(negedge clk_1hz);
    chk("en_drop_chime", chime, 0);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_left", sl, 0);
    en = 1'b1;

    // Reset mid-sequence, then a fresh trigger
    wait_idle();
    set_time(8'h08, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_1hz);
      if (k == 0) second = 8'h01;
    end
    cr = 1'b1;
    @(negedge clk_1hz);
    chk("cr_mid_chime", chime, 0);
    chk("cr_mid_busy", busy, 0);
    chk("cr_mid_left", sl, 0);
    chk("cr_mid_busy_l", busy_l, 0);
    cr = 1'b0;
    set_time(8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run_seq("after_cr", 5);

    // Long strikes (ON=2, OFF=3) at 02:00 with man_trig while busy
    wait_idle();
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    set_time(8'h02, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_1hz);
      if (k == 0) second = 8'h01;
      chk($sformatf("long_chime_%0d", k), chime_l, pat[k]);
      chk($sformatf("long_busy_%0d", k), busy_l, 1);
      if (k == 1) man_trig = 1'b1;
      if (k == 2) man_trig = 1'b0;
    end
    @(negedge clk_1hz);
    chk("long_end_chime", chime_l, 0);
    chk("long_end_busy", busy_l, 0);
    chk("long_end_left", sl_l, 0);
    chk("man_busy_ignored", busy, 0);

    // Half hour with HALF_HOUR_EN=0 stays silent
    wait_idle();
    set_time(8'h09, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk_1hz);
    second = 8'h01;
    chk("half_dis_chime", chime_nh, 0);
    chk("half_dis_busy", busy_nh, 0);
    chk("half_en_chime", chime, 1);
    @(negedge clk_1hz);
    chk("half_en_busy_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
